// File: rtl/mp_csa_accumulator_pkg.sv
// Shared defaults, FSM state type and chunk-count helper for the carry-save accumulator.
package mp_pkg;

    localparam int DEF_WIDTH = 514;
    localparam int DEF_CHUNK = 103;
    localparam int DEF_MOD_W = 512;

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        SUB,
        DONE
    } mp_state_e;

    function automatic int nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/mp_csa_accumulator_if.sv
// Operation/resolve bus between the Montgomery loop controller and the accumulator.
interface mp_csa_accumulator_if
    import mp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MOD_W = DEF_MOD_W
) ();

    logic             acc_clear;
    logic             acc_add;
    logic             acc_shift;
    logic [WIDTH-1:0] in_a;
    logic [MOD_W-1:0] in_m;
    logic             start;
    logic             mode_sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             subtracted;
    logic             lsb0;
    logic             lsb1;

    modport master (
        output acc_clear, acc_add, acc_shift, in_a, in_m, start, mode_sub,
        input  busy, done, result, overflow, subtracted, lsb0, lsb1
    );

    modport slave (
        input  acc_clear, acc_add, acc_shift, in_a, in_m, start, mode_sub,
        output busy, done, result, overflow, subtracted, lsb0, lsb1
    );

endinterface

// File: rtl/mp_csa_accumulator_chunk_adder.sv
// One CHUNK-bit slice of the carry-propagate adder, shared by resolve and subtract.
module mp_chunk_adder
    import mp_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/mp_csa_accumulator.sv
// Redundant (S, C) accumulator with chunked resolve to binary and optional
// conditional subtraction of the modulus.
module mp_csa_accumulator
    import mp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK,
    parameter int MOD_W = DEF_MOD_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    mp_csa_accumulator_if.slave  bus
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int PAD_W  = NCHUNK * CHUNK;
    localparam int LAST_W = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

    mp_state_e        state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH:0]   c_q, c_d;
    logic [CNT_W-1:0] chunk_q, chunk_d;
    logic             cy_q, cy_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             overflow_q, overflow_d;
    logic             subtracted_q, subtracted_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sum_bits;
    logic [WIDTH-1:0] maj_bits;
    logic [WIDTH:0]   car_bits;
    logic [WIDTH-1:0] m_ext;
    logic [PAD_W-1:0] s_pad, c_pad, r_pad, nm_pad;
    logic [CHUNK-1:0] op_a, op_b, add_sum;
    logic             add_cout;
    logic             last_carry;
    logic             chunk_carry;
    logic             last_chunk;
    int               chunk_idx;
    logic [WIDTH-1:0] res_merge, diff_merge;

    // The carry out of position WIDTH-1 lands in C[WIDTH]; an already-set C[WIDTH]
    // is kept so that an earlier overflow is not forgotten by later adds.
    always_comb begin
        sum_bits = s_q ^ c_q[WIDTH-1:0] ^ bus.in_a;
        maj_bits = (s_q & c_q[WIDTH-1:0]) | (s_q & bus.in_a) | (c_q[WIDTH-1:0] & bus.in_a);
        car_bits = {maj_bits[WIDTH-1] | c_q[WIDTH], maj_bits[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        m_ext              = '0;
        m_ext[MOD_W-1:0]   = bus.in_m;
        s_pad              = '0;
        s_pad[WIDTH-1:0]   = s_q;
        c_pad              = '0;
        c_pad[WIDTH-1:0]   = c_q[WIDTH-1:0];
        r_pad              = '0;
        r_pad[WIDTH-1:0]   = result_q;
        nm_pad             = '0;
        nm_pad[WIDTH-1:0]  = ~m_ext;
    end

    assign chunk_idx  = int'(chunk_q);
    assign last_chunk = (chunk_q == LAST_IDX);

    // Operand mux: RESOLVE adds S+C, SUB adds R+~M; padding above WIDTH is zero.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (k == chunk_idx) begin
                op_a = (state_q == SUB) ? r_pad[k*CHUNK +: CHUNK]  : s_pad[k*CHUNK +: CHUNK];
                op_b = (state_q == SUB) ? nm_pad[k*CHUNK +: CHUNK] : c_pad[k*CHUNK +: CHUNK];
            end
        end
    end

    mp_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (cy_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // A short last chunk has zero operands above LAST_W, so its carry sits in the sum.
    if (LAST_W == CHUNK) begin : g_full_last
        assign last_carry = add_cout;
    end else begin : g_part_last
        assign last_carry = add_sum[LAST_W];
    end

    assign chunk_carry = last_chunk ? last_carry : add_cout;

    always_comb begin
        res_merge  = result_q;
        diff_merge = diff_q;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i / CHUNK) == chunk_idx) begin
                res_merge[i]  = add_sum[i % CHUNK];
                diff_merge[i] = add_sum[i % CHUNK];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        c_d          = c_q;
        chunk_d      = chunk_q;
        cy_d         = cy_q;
        mode_d       = mode_q;
        result_d     = result_q;
        diff_d       = diff_q;
        overflow_d   = overflow_q;
        subtracted_d = subtracted_q;

        unique case (state_q)
            IDLE: begin
                if (bus.acc_clear) begin
                    s_d = '0;
                    c_d = '0;
                end else if (bus.acc_shift) begin
                    s_d = {1'b0, sum_bits[WIDTH-1:1]};
                    c_d = {1'b0, car_bits[WIDTH:1]};
                end else if (bus.acc_add) begin
                    s_d = sum_bits;
                    c_d = car_bits;
                end
                if (bus.start) begin
                    state_d      = RESOLVE;
                    chunk_d      = '0;
                    cy_d         = 1'b0;
                    mode_d       = bus.mode_sub;
                    overflow_d   = 1'b0;
                    subtracted_d = 1'b0;
                end
            end
            RESOLVE: begin
                result_d = res_merge;
                cy_d     = chunk_carry;
                chunk_d  = chunk_q + 1'b1;
                if (last_chunk) begin
                    overflow_d = chunk_carry | c_q[WIDTH];
                    chunk_d    = '0;
                    if (mode_q) begin
                        state_d = SUB;
                        cy_d    = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SUB: begin
                diff_d  = diff_merge;
                cy_d    = chunk_carry;
                chunk_d = chunk_q + 1'b1;
                if (last_chunk) begin
                    chunk_d = '0;
                    state_d = DONE;
                    // Overflow acts as bit WIDTH of R, so it forces the subtract.
                    if (chunk_carry || overflow_q) begin
                        result_d     = diff_merge;
                        subtracted_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != IDLE);
    assign done_d = (state_d == DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            s_q          <= '0;
            c_q          <= '0;
            chunk_q      <= '0;
            cy_q         <= 1'b0;
            mode_q       <= 1'b0;
            result_q     <= '0;
            diff_q       <= '0;
            overflow_q   <= 1'b0;
            subtracted_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            c_q          <= c_d;
            chunk_q      <= chunk_d;
            cy_q         <= cy_d;
            mode_q       <= mode_d;
            result_q     <= result_d;
            diff_q       <= diff_d;
            overflow_q   <= overflow_d;
            subtracted_q <= subtracted_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.overflow   = overflow_q;
    assign bus.subtracted = subtracted_q;
    assign bus.lsb0       = s_q[0] ^ c_q[0];
    assign bus.lsb1       = s_q[1] ^ c_q[1] ^ (s_q[0] & c_q[0]);

endmodule

// File: tb/tb_mp_csa_accumulator.sv
// Directed checks on the default 514-bit accumulator plus a randomised sweep of a
// 16-bit / 5-bit-chunk instance against an integer model of the accumulated sum.
module tb_mp_csa_accumulator;

    logic clk;
    logic resetn;

    mp_csa_accumulator_if #(.WIDTH(514), .MOD_W(512)) bigIf ();
    mp_csa_accumulator_if #(.WIDTH(16),  .MOD_W(15))  smallIf ();

    mp_csa_accumulator #(.WIDTH(514), .CHUNK(103), .MOD_W(512)) dutBig (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bigIf.slave)
    );

    mp_csa_accumulator #(.WIDTH(16), .CHUNK(5), .MOD_W(15)) dutSmall (
        .clk    (clk),
        .resetn (resetn),
        .bus    (smallIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           vectorCount;
    int           missCount;
    int           cycles;
    logic         busyEarly;
    logic         sawDone;
    logic [513:0] allOnes;
    logic [513:0] expWide;
    longint       total;
    int           nOps;
    logic [15:0]  aVal;
    logic         modeVal;
    logic [14:0]  mVal;
    logic [15:0]  expR;
    logic         expOv;
    logic         expSub;

    task automatic checkOutput(input string tag, input logic [599:0] observed, input logic [599:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One accumulator operation on the wide instance, held across one rising edge.
    task automatic applyStimulus(input logic clr, input logic add, input logic shf, input logic [513:0] a);
        @(negedge clk);
        bigIf.acc_clear = clr;
        bigIf.acc_add   = add;
        bigIf.acc_shift = shf;
        bigIf.in_a      = a;
        @(negedge clk);
        bigIf.acc_clear = 1'b0;
        bigIf.acc_add   = 1'b0;
        bigIf.acc_shift = 1'b0;
        bigIf.in_a      = '0;
    endtask

    task automatic applySmall(input logic clr, input logic add, input logic shf, input logic [15:0] a);
        @(negedge clk);
        smallIf.acc_clear = clr;
        smallIf.acc_add   = add;
        smallIf.acc_shift = shf;
        smallIf.in_a      = a;
        @(negedge clk);
        smallIf.acc_clear = 1'b0;
        smallIf.acc_add   = 1'b0;
        smallIf.acc_shift = 1'b0;
        smallIf.in_a      = '0;
    endtask

    // Start a resolve on the wide instance and count negedges until done is seen.
    // injectKind 1 pulses acc_add at cycle injectAt, kind 2 pulses start with mode_sub=1.
    task automatic runResolve(input logic mode, input logic [511:0] m, input logic preAdd,
                              input logic [513:0] preVal, input int injectAt, input int injectKind,
                              output int cyc, output logic busyFirst);
        @(negedge clk);
        bigIf.in_m     = m;
        bigIf.mode_sub = mode;
        bigIf.start    = 1'b1;
        bigIf.acc_add  = preAdd;
        bigIf.in_a     = preVal;
        @(negedge clk);
        bigIf.start    = 1'b0;
        bigIf.mode_sub = 1'b0;
        bigIf.acc_add  = 1'b0;
        bigIf.in_a     = '0;
        cyc       = 1;
        busyFirst = bigIf.busy;
        while (bigIf.done !== 1'b1 && cyc < 50) begin
            if (cyc == injectAt) begin
                if (injectKind == 1) begin
                    bigIf.acc_add = 1'b1;
                    bigIf.in_a    = 514'd5;
                end else begin
                    bigIf.start    = 1'b1;
                    bigIf.mode_sub = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
            bigIf.acc_add  = 1'b0;
            bigIf.in_a     = '0;
            bigIf.start    = 1'b0;
            bigIf.mode_sub = 1'b0;
        end
    endtask

    task automatic runSmall(input logic mode, input logic [14:0] m, output int cyc);
        @(negedge clk);
        smallIf.in_m     = m;
        smallIf.mode_sub = mode;
        smallIf.start    = 1'b1;
        @(negedge clk);
        smallIf.start    = 1'b0;
        smallIf.mode_sub = 1'b0;
        cyc = 1;
        while (smallIf.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        vectorCount = 0;
        missCount   = 0;
        resetn      = 1'b0;
        allOnes     = '1;
        bigIf.acc_clear   = 1'b0;
        bigIf.acc_add     = 1'b0;
        bigIf.acc_shift   = 1'b0;
        bigIf.in_a        = '0;
        bigIf.in_m        = '0;
        bigIf.start       = 1'b0;
        bigIf.mode_sub    = 1'b0;
        smallIf.acc_clear = 1'b0;
        smallIf.acc_add   = 1'b0;
        smallIf.acc_shift = 1'b0;
        smallIf.in_a      = '0;
        smallIf.in_m      = '0;
        smallIf.start     = 1'b0;
        smallIf.mode_sub  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_flags", {bigIf.busy, bigIf.done, bigIf.overflow, bigIf.subtracted, bigIf.lsb0}, 5'b0);
        checkOutput("rst_result", bigIf.result, 0);
        resetn = 1'b1;

        // 5 + 7 resolved without subtraction
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 514'd5);
        applyStimulus(1'b0, 1'b1, 1'b0, 514'd7);
        runResolve(1'b0, '0, 1'b0, '0, 0, 0, cycles, busyEarly);
        checkOutput("add_latency", cycles, 6);
        checkOutput("add_busy", busyEarly, 1);
        checkOutput("add_result", bigIf.result, 12);
        checkOutput("add_flags", {bigIf.overflow, bigIf.subtracted}, 2'b00);
        @(negedge clk);
        checkOutput("done_pulse", {bigIf.busy, bigIf.done}, 2'b00);
        checkOutput("result_hold", bigIf.result, 12);

        // (2^514-1) twice: 2^515-2, low bits 2^514-2 and C[514] gives overflow
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, allOnes);
        applyStimulus(1'b0, 1'b1, 1'b0, allOnes);
        runResolve(1'b0, '0, 1'b0, '0, 0, 0, cycles, busyEarly);
        expWide    = allOnes;
        expWide[0] = 1'b0;
        checkOutput("ones_result", bigIf.result, expWide);
        checkOutput("ones_ovf", bigIf.overflow, 1);

        // (2^514-1) + 1 = 2^514: carry must ripple through every chunk
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, allOnes);
        applyStimulus(1'b0, 1'b1, 1'b0, 514'd1);
        runResolve(1'b0, '0, 1'b0, '0, 0, 0, cycles, busyEarly);
        checkOutput("ripple_result", bigIf.result, 0);
        checkOutput("ripple_ovf", bigIf.overflow, 1);

        // Conditional subtract against M = 97
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 514'd100);
        runResolve(1'b1, 512'd97, 1'b0, '0, 0, 0, cycles, busyEarly);
        checkOutput("sub_latency", cycles, 11);
        checkOutput("sub_gt", {bigIf.subtracted, bigIf.overflow, bigIf.result}, {1'b1, 1'b0, 514'd3});
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 514'd96);
        runResolve(1'b1, 512'd97, 1'b0, '0, 0, 0, cycles, busyEarly);
        checkOutput("sub_lt", {bigIf.subtracted, bigIf.overflow, bigIf.result}, {1'b0, 1'b0, 514'd96});
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 514'd97);
        runResolve(1'b1, 512'd97, 1'b0, '0, 0, 0, cycles, busyEarly);
        checkOutput("sub_eq", {bigIf.subtracted, bigIf.overflow, bigIf.result}, {1'b1, 1'b0, 514'd0});

        // Add 3 then shift with a=1: (3+1)>>1 = 2
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 514'd3);
        checkOutput("lsb_pre_shift", {bigIf.lsb1, bigIf.lsb0}, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b1, 514'd1);
        checkOutput("lsb_post_shift", {bigIf.lsb1, bigIf.lsb0}, 2'b10);
        runResolve(1'b0, '0, 1'b0, '0, 0, 0, cycles, busyEarly);
        checkOutput("shift_result", bigIf.result, 2);

        // acc_add while busy is ignored, both in this result and the next one
        runResolve(1'b0, '0, 1'b0, '0, 2, 1, cycles, busyEarly);
        checkOutput("busy_add_result", bigIf.result, 2);
        runResolve(1'b0, '0, 1'b0, '0, 0, 0, cycles, busyEarly);
        checkOutput("busy_add_frozen", bigIf.result, 2);

        // A second start mid-RESOLVE is neither taken nor queued
        runResolve(1'b0, 512'd1, 1'b0, '0, 2, 2, cycles, busyEarly);
        checkOutput("restart_latency", cycles, 6);
        checkOutput("restart_result", {bigIf.subtracted, bigIf.result}, {1'b0, 514'd2});
        repeat (2) @(negedge clk);
        checkOutput("restart_no_queue", bigIf.busy, 0);

        // acc_add together with start: the resolve sees 10 + 20
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 514'd10);
        runResolve(1'b0, '0, 1'b1, 514'd20, 0, 0, cycles, busyEarly);
        checkOutput("same_cycle_result", bigIf.result, 30);

        // Reset in the middle of RESOLVE
        @(negedge clk);
        bigIf.start = 1'b1;
        @(negedge clk);
        bigIf.start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("midrst_busy", bigIf.busy, 0);
        checkOutput("midrst_result", bigIf.result, 0);
        sawDone = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bigIf.done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("midrst_no_done", sawDone, 0);
        resetn = 1'b1;
        runResolve(1'b0, '0, 1'b0, '0, 0, 0, cycles, busyEarly);
        checkOutput("midrst_acc_cleared", {bigIf.overflow, bigIf.result}, 0);

        // Randomised sequences on the 16-bit instance (4 chunks, last one 1 bit wide)
        for (int seq = 0; seq < 1000; seq++) begin
            applySmall(1'b1, 1'b0, 1'b0, '0);
            total = 0;
            nOps  = $urandom_range(1, 4);
            for (int k = 0; k < nOps; k++) begin
                aVal = 16'($urandom_range(0, 65535));
                if ($urandom_range(0, 2) == 0 && (total + aVal) < 131072) begin
                    applySmall(1'b0, 1'b0, 1'b1, aVal);
                    total = (total + aVal) >> 1;
                end else begin
                    applySmall(1'b0, 1'b1, 1'b0, aVal);
                    total = total + aVal;
                end
            end
            checkOutput("rnd_lsb", {smallIf.lsb1, smallIf.lsb0}, total[1:0]);
            modeVal = 1'($urandom_range(0, 1));
            mVal    = 15'($urandom_range(1, 32767));
            expR    = total[15:0];
            expOv   = (total >= 65536);
            expSub  = 1'b0;
            if (modeVal && (expOv || expR >= {1'b0, mVal})) begin
                expR   = expR - {1'b0, mVal};
                expSub = 1'b1;
            end
            runSmall(modeVal, mVal, cycles);
            checkOutput("rnd_resolve",
                        {cycles[7:0], smallIf.subtracted, smallIf.overflow, smallIf.result},
                        {(modeVal ? 8'd9 : 8'd5), expSub, expOv, expR});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
